// File: rtl/gcd_unit.sv
// GCD of two unsigned WIDTH-bit operands by repeated subtraction, with valid/ready
// handshakes on both sides. Define GCD_CYCLE_COUNT_EN to add the saturating 'cycles' output.
module gcd_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [WIDTH-1:0] cycles
`endif
);

    // Handshake rule: a transfer happens on a rising edge where valid and ready are
    // both high; valid is held by the sender until that edge, ready may change freely.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // in_ready/out_valid/busy are registered alongside the state so they are glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a_in;
                        b_q      <= b_in;
                        in_ready <= 1'b0;
                        if (a_in == '0 || b_in == '0) begin
                            result    <= a_in | b_in;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (a_q > b_q) begin
                        a_q <= a_q - b_q;
                    end else if (b_q > a_q) begin
                        b_q <= b_q - a_q;
                    end else begin
                        result    <= a_q;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // No accept in the handoff cycle: in_ready rises only after this edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    // Counts every CALC edge, including the final equal-compare one; saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles <= '0;
        end else if (state == IDLE && in_valid) begin
            cycles <= '0;
        end else if (state == CALC && cycles != {WIDTH{1'b1}}) begin
            cycles <= cycles + 1'b1;
        end
    end
`endif

endmodule
